alu_rs: RTL and testbench
=========================

// Module: alu_rs
// PURPOSE
// - ALU reservation station between the ID/dispatch stage and the ALU.
// - Holds up to RS_DEPTH dispatched ALU ops and captures missing operands from the ALU result bus
//   (the same target/result pair the ROB receives).
// - Issues the oldest fully-ready op to the ALU through a registered valid/ready handshake.
// PARAMETERS
// - RS_DEPTH  4   station entries (>=2)
// - DATA_W    32  operand/result width (COMMON_WIDTH)
// - TAG_W     5   ROB tag width; valid tags 0..ROB_ENTRY_NUM-1; TAG_INVALID = {TAG_W{1'b1}}
// - OP_W      6   ALU opcode width (OP_TYPE_WIDTH)
// PORTS
// - clk            in   1       clock
// - rst            in   1       asynchronous, active-high reset
// - flush          in   1       synchronous squash of all entries and the issue register
// - disp_valid     in   1       dispatch request
// - disp_ready     out  1       station not full
// - disp_op        in   OP_W    ALU opcode
// - disp_dest      in   TAG_W   ROB tag of the result
// - disp_s1_rdy    in   1       src1 value is present in disp_s1_val
// - disp_s1_val    in   DATA_W  src1 value (when rdy)
// - disp_s1_tag    in   TAG_W   src1 producer tag (when !rdy)
// - disp_s2_rdy/disp_s2_val/disp_s2_tag   as src1
// - cdb_tag        in   TAG_W   ALU result target; TAG_INVALID = no result this cycle
// - cdb_val        in   DATA_W  ALU result value
// - iss_valid      out  1       issue register holds an op
// - iss_ready      in   1       ALU accepts the op
// - iss_op         out  OP_W    issued opcode
// - iss_a, iss_b   out  DATA_W  issued operands
// - iss_dest       out  TAG_W   issued ROB tag
// BEHAVIOUR
// - Reset (async): all entries invalid; age matrix cleared; iss_valid=0; iss_op/iss_a/iss_b=0;
//   iss_dest=TAG_INVALID. disp_ready=1 after reset.
// - Entry fields: valid, op, dest, and {rdy, val, tag} per source.
// - disp_ready = !(all entries valid); combinational from state only; no credit for same-cycle issue.
// - Dispatch (disp_valid && disp_ready): write lowest-index free entry at the clock edge.
//   - Entry becomes youngest in the age matrix.
//   - If a source is !rdy and its tag == cdb_tag in the same cycle, capture cdb_val and set rdy=1.
//   - A dispatched source with rdy=0 and tag=TAG_INVALID is illegal (assertion).
// - Wakeup: every valid entry with src !rdy and tag == cdb_tag (cdb_tag != TAG_INVALID) latches
//   cdb_val, sets rdy. Both sources may wake on the same cycle.
// - Select: candidates = valid && s1.rdy && s2.rdy. Pick the oldest via the age matrix
//   (older[i][j] = 1 if i was dispatched before j).
// - Issue register loads when (!iss_valid || iss_ready) and a candidate exists.
//   - The selected entry is freed at the same edge.
//   - If no candidate exists and iss_ready: iss_valid drops to 0.
// - Hold: while iss_valid && !iss_ready, all iss_* outputs stay stable.
// - Latency:
//   - Dispatch with both operands ready, accepted in cycle N -> iss_valid in cycle N+2 (empty RS,
//     iss_ready=1).
//   - Wakeup in cycle N -> issue at N+2.
//   - Back-to-back issue: 1 op per cycle.
// - Simultaneous dispatch + issue in one cycle is allowed.
//   - A freed slot becomes visible to disp_ready the next cycle.
// - flush: at the edge, clear all entries and iss_valid (iss_dest=TAG_INVALID).
//   - Overrides dispatch, wakeup and issue in that cycle; disp_ready=1 next cycle.
// - rst mid-operation: immediate clear; no partial issue survives.
// - Tags are compared as raw TAG_W values; no wrap arithmetic is needed because ROB tags are unique
//   while in flight.
// STRUCTURE
// - Shared package (common_def): TAG_INVALID, COMMON_WIDTH, INST_TAG_WIDTH, OP_TYPE_WIDTH, and an
//   rs_entry_t typedef {valid, op, dest, s1, s2} with src_t {rdy, val, tag}.
// - Sub-module rs_age_pick: RS_DEPTH x RS_DEPTH age matrix plus a one-hot oldest-ready picker.
//   - Inputs: insert one-hot, free one-hot, request vector.
//   - Output: grant one-hot.
// - alu_rs holds entries, wakeup compare, free-slot priority encoder and the issue register.
// TESTING
// - Reset: assert rst mid-run -> iss_valid=0, iss_dest=5'h1F, disp_ready=1 immediately.
// - Ready dispatch: empty RS, op=ADD, s1=5, s2=7 both rdy, dest=3, iss_ready=1 -> cycle+2 shows
//   iss_valid=1, iss_a=5, iss_b=7, iss_dest=3.
// - Wakeup, same cycle: dispatch dest=4 with s2 !rdy tag=9 while cdb_tag=9, cdb_val=0x20 ->
//   issues with iss_b=0x20.
// - Wakeup, later: dispatch with s2 !rdy tag=9; cdb_tag=9 two cycles later -> issues with
//   iss_b=0x20 two cycles after the cdb cycle.
// - Oldest-first: fill 4 entries (dests 1,2,3,4); make 4 then 2 then 1 ready in the same cycle
//   -> issue order 1,2,4; 3 stays held.
// - Full/backpressure: 4 entries, iss_ready=0 -> disp_ready=0, iss_* stable for 5 cycles;
//   iss_ready=1 -> one issue per cycle; disp_ready=1 on the cycle after the first free.
// - Flush: flush with 3 entries and iss_valid=1 -> next cycle iss_valid=0, disp_ready=1;
//   a later cdb_tag matching an old source causes no issue.

Source files
------------

// File: rtl/alu_rs_pkg.sv
// Shared definitions for the ALU reservation station.
// Provides the common widths, the invalid-tag marker, the station entry
// layout and the operand wakeup helper used by both dispatch and wakeup.
package alu_rs_pkg;

  localparam int unsigned COMMON_WIDTH   = 32;
  localparam int unsigned INST_TAG_WIDTH = 5;
  localparam int unsigned OP_TYPE_WIDTH  = 6;

  localparam logic [INST_TAG_WIDTH-1:0] TAG_INVALID = '1;

  typedef struct packed {
    logic                      rdy;
    logic [COMMON_WIDTH-1:0]   val;
    logic [INST_TAG_WIDTH-1:0] tag;
  } src_t;

  typedef struct packed {
    logic                      valid;
    logic [OP_TYPE_WIDTH-1:0]  op;
    logic [INST_TAG_WIDTH-1:0] dest;
    src_t                      s1;
    src_t                      s2;
  } rs_entry_t;

  // Returns the source with the result bus value captured when it is still
  // waiting on the producer currently broadcasting.
  function automatic src_t src_capture(input src_t                      s,
                                       input logic [INST_TAG_WIDTH-1:0] cdb_tag,
                                       input logic [COMMON_WIDTH-1:0]   cdb_val);
    src_t r;
    r = s;
    if (!s.rdy && (s.tag == cdb_tag) && (cdb_tag != TAG_INVALID)) begin
      r.rdy = 1'b1;
      r.val = cdb_val;
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_rs_age_pick.sv
// rs_age_pick: age matrix and oldest-request picker for the reservation station.
// Ports:
//   clk, rst   clock and asynchronous active-high reset (matrix cleared)
//   i_insert   one-hot slot being written this edge (becomes youngest)
//   i_free     slots being released this edge (all ones squashes everything)
//   i_req      slots eligible for selection
//   o_grant    one-hot oldest requesting slot (zero when no request)
module rs_age_pick #(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH-1:0] i_insert,
  input  logic [DEPTH-1:0] i_free,
  input  logic [DEPTH-1:0] i_req,
  output logic [DEPTH-1:0] o_grant
);

  // r_older[i][j] = 1 when slot i was written before slot j.
  logic [DEPTH-1:0] r_older [DEPTH];
  logic [DEPTH-1:0] w_blocked;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_older[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        for (int unsigned j = 0; j < DEPTH; j++) begin
          // A new entry is younger than every other slot; stale bits for
          // empty slots are harmless because requests mask them out.
          if (i_insert[j])                 r_older[i][j] <= (i != j);
          else if (i_insert[i])            r_older[i][j] <= 1'b0;
          else if (i_free[i] || i_free[j]) r_older[i][j] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_blocked = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if ((i != j) && i_req[j] && r_older[j][i]) w_blocked[i] = 1'b1;
      end
    end
  end

  assign o_grant = i_req & ~w_blocked;

endmodule

// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station between dispatch and the ALU.
// Holds up to RS_DEPTH ops, captures missing operands from the ALU result
// bus and issues the oldest fully-ready op through a registered
// valid/ready issue stage.
// Ports:
//   clk, rst, flush                 clock, async active-high reset, sync squash
//   disp_*                          dispatch request, opcode, dest tag, sources
//   disp_ready                      station not full (state only)
//   cdb_tag, cdb_val                ALU result broadcast (tag all-ones = none)
//   iss_valid/iss_ready             issue handshake
//   iss_op, iss_a, iss_b, iss_dest  issued op
// Widths are tied to the shared entry layout; only RS_DEPTH is freely sizable.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int unsigned RS_DEPTH = 4,
  parameter int unsigned DATA_W   = COMMON_WIDTH,
  parameter int unsigned TAG_W    = INST_TAG_WIDTH,
  parameter int unsigned OP_W     = OP_TYPE_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic [OP_W-1:0]   disp_op,
  input  logic [TAG_W-1:0]  disp_dest,
  input  logic              disp_s1_rdy,
  input  logic [DATA_W-1:0] disp_s1_val,
  input  logic [TAG_W-1:0]  disp_s1_tag,
  input  logic              disp_s2_rdy,
  input  logic [DATA_W-1:0] disp_s2_val,
  input  logic [TAG_W-1:0]  disp_s2_tag,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_val,
  output logic              iss_valid,
  input  logic              iss_ready,
  output logic [OP_W-1:0]   iss_op,
  output logic [DATA_W-1:0] iss_a,
  output logic [DATA_W-1:0] iss_b,
  output logic [TAG_W-1:0]  iss_dest
);

  localparam logic [TAG_W-1:0] L_TAG_INV = '1;

  rs_entry_t            r_ent [RS_DEPTH];
  rs_entry_t            w_new;
  logic [RS_DEPTH-1:0]  w_valid;
  logic [RS_DEPTH-1:0]  w_req;
  logic [RS_DEPTH-1:0]  w_slot;
  logic                 w_found;
  logic [RS_DEPTH-1:0]  w_ins;
  logic [RS_DEPTH-1:0]  w_grant;
  logic [RS_DEPTH-1:0]  w_issue;
  logic [RS_DEPTH-1:0]  w_pick_free;
  logic                 w_load;
  logic [OP_W-1:0]      w_sel_op;
  logic [DATA_W-1:0]    w_sel_a;
  logic [DATA_W-1:0]    w_sel_b;
  logic [TAG_W-1:0]     w_sel_dest;

  always_comb begin
    for (int unsigned i = 0; i < RS_DEPTH; i++) begin
      w_valid[i] = r_ent[i].valid;
      w_req[i]   = r_ent[i].valid && r_ent[i].s1.rdy && r_ent[i].s2.rdy;
    end
  end

  assign disp_ready = ~(&w_valid);

  // Lowest-index free slot.
  always_comb begin
    w_slot  = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < RS_DEPTH; i++) begin
      if (!w_valid[i] && !w_found) begin
        w_slot[i] = 1'b1;
        w_found   = 1'b1;
      end
    end
  end

  assign w_ins       = (disp_valid && disp_ready && !flush) ? w_slot : '0;
  assign w_load      = (!iss_valid || iss_ready) && (|w_req) && !flush;
  assign w_issue     = w_load ? w_grant : '0;
  assign w_pick_free = flush ? '1 : w_issue;

  rs_age_pick #(
    .DEPTH (RS_DEPTH)
  ) u_age_pick (
    .clk      (clk),
    .rst      (rst),
    .i_insert (w_ins),
    .i_free   (w_pick_free),
    .i_req    (w_req),
    .o_grant  (w_grant)
  );

  // Incoming entry, with same-cycle operand capture from the result bus.
  always_comb begin
    w_new.valid  = 1'b1;
    w_new.op     = disp_op;
    w_new.dest   = disp_dest;
    w_new.s1.rdy = disp_s1_rdy;
    w_new.s1.val = disp_s1_val;
    w_new.s1.tag = disp_s1_tag;
    w_new.s2.rdy = disp_s2_rdy;
    w_new.s2.val = disp_s2_val;
    w_new.s2.tag = disp_s2_tag;
    w_new.s1     = src_capture(w_new.s1, cdb_tag, cdb_val);
    w_new.s2     = src_capture(w_new.s2, cdb_tag, cdb_val);
  end

  always_comb begin
    w_sel_op   = '0;
    w_sel_a    = '0;
    w_sel_b    = '0;
    w_sel_dest = '0;
    for (int unsigned i = 0; i < RS_DEPTH; i++) begin
      if (w_grant[i]) begin
        w_sel_op   = r_ent[i].op;
        w_sel_a    = r_ent[i].s1.val;
        w_sel_b    = r_ent[i].s2.val;
        w_sel_dest = r_ent[i].dest;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < RS_DEPTH; i++) r_ent[i] <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < RS_DEPTH; i++) r_ent[i].valid <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < RS_DEPTH; i++) begin
        if (w_ins[i]) begin
          r_ent[i] <= w_new;
        end else if (w_issue[i]) begin
          r_ent[i].valid <= 1'b0;
        end else if (r_ent[i].valid) begin
          r_ent[i].s1 <= src_capture(r_ent[i].s1, cdb_tag, cdb_val);
          r_ent[i].s2 <= src_capture(r_ent[i].s2, cdb_tag, cdb_val);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_valid <= 1'b0;
      iss_op    <= '0;
      iss_a     <= '0;
      iss_b     <= '0;
      iss_dest  <= L_TAG_INV;
    end else if (flush) begin
      iss_valid <= 1'b0;
      iss_dest  <= L_TAG_INV;
    end else if (w_load) begin
      iss_valid <= 1'b1;
      iss_op    <= w_sel_op;
      iss_a     <= w_sel_a;
      iss_b     <= w_sel_b;
      iss_dest  <= w_sel_dest;
    end else if (iss_ready) begin
      iss_valid <= 1'b0;
    end
  end

  // A waiting source must name a real producer.
  a_disp_src_tag: assert property (@(posedge clk) disable iff (rst)
    (disp_valid && disp_ready) |->
      ((disp_s1_rdy || (disp_s1_tag != L_TAG_INV)) &&
       (disp_s2_rdy || (disp_s2_tag != L_TAG_INV))));

endmodule

// File: tb/tb_alu_rs.sv
module tb_alu_rs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        disp_valid = 1'b0;
  logic        disp_ready;
  logic [5:0]  disp_op = '0;
  logic [4:0]  disp_dest = '0;
  logic        disp_s1_rdy = 1'b0;
  logic [31:0] disp_s1_val = '0;
  logic [4:0]  disp_s1_tag = '0;
  logic        disp_s2_rdy = 1'b0;
  logic [31:0] disp_s2_val = '0;
  logic [4:0]  disp_s2_tag = '0;
  logic [4:0]  cdb_tag = 5'h1F;
  logic [31:0] cdb_val = '0;
  logic        iss_valid;
  logic        iss_ready = 1'b1;
  logic [5:0]  iss_op;
  logic [31:0] iss_a;
  logic [31:0] iss_b;
  logic [4:0]  iss_dest;

  alu_rs #(
    .RS_DEPTH (4),
    .DATA_W   (32),
    .TAG_W    (5),
    .OP_W     (6)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .disp_valid  (disp_valid),
    .disp_ready  (disp_ready),
    .disp_op     (disp_op),
    .disp_dest   (disp_dest),
    .disp_s1_rdy (disp_s1_rdy),
    .disp_s1_val (disp_s1_val),
    .disp_s1_tag (disp_s1_tag),
    .disp_s2_rdy (disp_s2_rdy),
    .disp_s2_val (disp_s2_val),
    .disp_s2_tag (disp_s2_tag),
    .cdb_tag     (cdb_tag),
    .cdb_val     (cdb_val),
    .iss_valid   (iss_valid),
    .iss_ready   (iss_ready),
    .iss_op      (iss_op),
    .iss_a       (iss_a),
    .iss_b       (iss_b),
    .iss_dest    (iss_dest)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dest;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Scoreboard monitor: every accepted issue is compared with the oldest expectation.
  always @(negedge clk) begin
    if (!rst && iss_valid && iss_ready) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_issue: got dest=%0h a=%0h b=%0h, none expected (cycle %0d)",
                 iss_dest, iss_a, iss_b, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (iss_op !== e.op || iss_a !== e.a || iss_b !== e.b || iss_dest !== e.dest ||
            (e.cyc >= 0 && cyc != e.cyc)) begin
          failures++;
          $display("FAIL issue_dest%0h: got op=%0h a=%0h b=%0h dest=%0h cyc=%0d expected op=%0h a=%0h b=%0h dest=%0h cyc=%0d",
                   e.dest, iss_op, iss_a, iss_b, iss_dest, cyc, e.op, e.a, e.b, e.dest, e.cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] dest, input int c);
    exp_t e;
    e.op = op; e.a = a; e.b = b; e.dest = dest; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic disp(input logic [5:0] op, input logic [4:0] dest,
                      input logic r1, input logic [31:0] v1, input logic [4:0] t1,
                      input logic r2, input logic [31:0] v2, input logic [4:0] t2);
    disp_valid  = 1'b1;
    disp_op     = op;
    disp_dest   = dest;
    disp_s1_rdy = r1; disp_s1_val = v1; disp_s1_tag = t1;
    disp_s2_rdy = r2; disp_s2_val = v2; disp_s2_tag = t2;
    step();
    disp_valid  = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 40; k++) begin
      if (q.size() == 0 && !iss_valid) break;
      step();
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    step(); step();
    chk("rst_iss_valid", 64'(iss_valid), 64'd0);
    chk("rst_iss_dest", 64'(iss_dest), 64'h1F);
    chk("rst_iss_a", 64'(iss_a), 64'd0);
    chk("rst_disp_ready", 64'(disp_ready), 64'd1);
    rst = 1'b0;
    step();

    // Both operands ready: issue two cycles after dispatch
    n = cyc;
    push(6'h01, 32'd5, 32'd7, 5'd3, n + 2);
    disp(6'h01, 5'd3, 1'b1, 32'd5, 5'd0, 1'b1, 32'd7, 5'd0);
    chk("no_early_issue", 64'(iss_valid), 64'd0);
    drain();

    // Same-cycle capture from the result bus
    n = cyc;
    push(6'h02, 32'h11, 32'h20, 5'd4, n + 2);
    cdb_tag = 5'd9; cdb_val = 32'h20;
    disp(6'h02, 5'd4, 1'b1, 32'h11, 5'd0, 1'b0, 32'h0, 5'd9);
    cdb_tag = 5'h1F;
    drain();

    // Later wakeup: result two cycles after dispatch
    n = cyc;
    push(6'h02, 32'h3, 32'h20, 5'd5, n + 4);
    disp(6'h02, 5'd5, 1'b1, 32'h3, 5'd0, 1'b0, 32'h0, 5'd9);
    step();
    cdb_tag = 5'd9; cdb_val = 32'h20;
    step();
    cdb_tag = 5'h1F;
    drain();

    // Oldest first: 1,2,4 wake together, 3 waits on another producer
    n = cyc;
    disp(6'd1, 5'd1, 1'b1, 32'h10, 5'd0, 1'b0, 32'h0, 5'hA);
    disp(6'd2, 5'd2, 1'b1, 32'h20, 5'd0, 1'b0, 32'h0, 5'hA);
    disp(6'd3, 5'd3, 1'b1, 32'h30, 5'd0, 1'b0, 32'h0, 5'hB);
    disp(6'd4, 5'd4, 1'b1, 32'h40, 5'd0, 1'b0, 32'h0, 5'hA);
    chk("full_disp_ready", 64'(disp_ready), 64'd0);
    push(6'd1, 32'h10, 32'h55, 5'd1, n + 6);
    push(6'd2, 32'h20, 32'h55, 5'd2, n + 7);
    push(6'd4, 32'h40, 32'h55, 5'd4, n + 8);
    cdb_tag = 5'hA; cdb_val = 32'h55;
    step();
    cdb_tag = 5'h1F;
    step();
    chk("ready_after_free", 64'(disp_ready), 64'd1);
    step(); step(); step(); step();
    push(6'd3, 32'h30, 32'h66, 5'd3, n + 12);
    cdb_tag = 5'hB; cdb_val = 32'h66;
    step();
    cdb_tag = 5'h1F;
    drain();

    // Backpressure with a full station
    iss_ready = 1'b0;
    n = cyc;
    for (int k = 0; k < 5; k++)
      push(6'd3, 32'((k + 6) * 16), 32'(k + 6), 5'(k + 6), n + 10 + k);
    for (int k = 0; k < 5; k++)
      disp(6'd3, 5'(k + 6), 1'b1, 32'((k + 6) * 16), 5'd0, 1'b1, 32'(k + 6), 5'd0);
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid", 64'(iss_valid), 64'd1);
      chk("hold_dest_a_b", {27'd0, iss_dest, iss_a}, {27'd0, 5'd6, 32'h60});
      chk("hold_disp_ready", 64'(disp_ready), 64'd0);
      step();
    end
    chk("bp_disp_ready_before", 64'(disp_ready), 64'd0);
    iss_ready = 1'b1;
    step();
    chk("bp_disp_ready_after", 64'(disp_ready), 64'd1);
    drain();

    // Flush with three entries and an op held for issue
    iss_ready = 1'b0;
    disp(6'd7, 5'd11, 1'b1, 32'h1, 5'd0, 1'b1, 32'h2, 5'd0);
    disp(6'd7, 5'd12, 1'b1, 32'h1, 5'd0, 1'b0, 32'h0, 5'h15);
    disp(6'd7, 5'd13, 1'b1, 32'h1, 5'd0, 1'b0, 32'h0, 5'h15);
    disp(6'd7, 5'd14, 1'b1, 32'h1, 5'd0, 1'b0, 32'h0, 5'h15);
    chk("pre_flush_dest", 64'(iss_dest), 64'd11);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_iss_valid", 64'(iss_valid), 64'd0);
    chk("flush_iss_dest", 64'(iss_dest), 64'h1F);
    chk("flush_disp_ready", 64'(disp_ready), 64'd1);
    iss_ready = 1'b1;
    cdb_tag = 5'h15; cdb_val = 32'h99;
    step();
    cdb_tag = 5'h1F;
    for (int k = 0; k < 4; k++) begin
      chk("flush_no_issue", 64'(iss_valid), 64'd0);
      step();
    end

    // Asynchronous reset mid-operation
    iss_ready = 1'b0;
    disp(6'd9, 5'd20, 1'b1, 32'h7, 5'd0, 1'b1, 32'h8, 5'd0);
    disp(6'd9, 5'd21, 1'b1, 32'h7, 5'd0, 1'b1, 32'h8, 5'd0);
    disp(6'd9, 5'd22, 1'b1, 32'h7, 5'd0, 1'b0, 32'h0, 5'h16);
    chk("pre_rst_dest", 64'(iss_dest), 64'd20);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_iss_valid", 64'(iss_valid), 64'd0);
    chk("mid_rst_iss_dest", 64'(iss_dest), 64'h1F);
    chk("mid_rst_disp_ready", 64'(disp_ready), 64'd1);
    chk("mid_rst_iss_a", 64'(iss_a), 64'd0);
    step();
    rst = 1'b0;
    iss_ready = 1'b1;
    cdb_tag = 5'h16; cdb_val = 32'h44;
    step();
    cdb_tag = 5'h1F;
    for (int k = 0; k < 4; k++) begin
      chk("rst_no_issue", 64'(iss_valid), 64'd0);
      step();
    end
    chk("final_queue_empty", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
